// File: rtl/video_frame_src.sv
// Raster coordinate source: walks hc/vc over the display area with an optional idle gap between frames.
// Optional frame_cnt output is built when `VIDEO_FRAME_SRC_FRAME_CNT_EN is defined.

`ifndef H_DISPLAY
`define H_DISPLAY 640
`endif
`ifndef V_DISPLAY
`define V_DISPLAY 480
`endif

package video_frame_src_pkg;
  localparam int unsigned HC_W    = 10;
  localparam int unsigned VC_W    = 10;
  localparam int unsigned COLOR_W = 8;

  typedef struct packed {
    logic [HC_W-1:0]    hc;
    logic [VC_W-1:0]    vc;
    logic               start;
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } vga_frame_t;
endpackage

module video_frame_src
  import video_frame_src_pkg::*;
#(
  parameter int unsigned FRAME_GAP = 0,
  parameter int unsigned H_DISPLAY = `H_DISPLAY,
  parameter int unsigned V_DISPLAY = `V_DISPLAY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       stall,
  output logic       sink_vld,
  output vga_frame_t sink_frame,
  output logic       frame_done,
  output logic       busy
`ifdef VIDEO_FRAME_SRC_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int unsigned GAP_W = 8;
  localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(H_DISPLAY - 1);
  localparam logic [VC_W-1:0]  VC_LAST  = VC_W'(V_DISPLAY - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    GAP
  } state_t;

  state_t           state_q, state_d;
  logic [HC_W-1:0]  hc_q, hc_d;
  logic [VC_W-1:0]  vc_q, vc_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             vld_d;
  vga_frame_t       frame_d;
  logic             done_d;
  logic             busy_d;
  logic             emit;
  logic             hc_last;
  logic             px_last;
  logic             gap_last;

  assign hc_last  = (hc_q == HC_LAST);
  assign px_last  = hc_last && (vc_q == VC_LAST);
  assign gap_last = (gap_q == GAP_LAST);

  // State, counters and registered outputs; everything holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hc_q       <= '0;
      vc_q       <= '0;
      gap_q      <= '0;
      sink_vld   <= 1'b0;
      sink_frame <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      hc_q       <= hc_d;
      vc_q       <= vc_d;
      gap_q      <= gap_d;
      sink_vld   <= vld_d;
      sink_frame <= frame_d;
      frame_done <= done_d;
      busy       <= busy_d;
    end
  end

  // Next state and output values. IDLE with enable launches pixel (0,0) directly
  // so the first pixel lands one clock after enable is sampled.
  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    vc_d    = vc_q;
    gap_d   = gap_q;
    vld_d   = sink_vld;
    frame_d = sink_frame;
    done_d  = frame_done;
    busy_d  = busy;
    emit    = 1'b0;

    if (!stall) begin
      vld_d   = 1'b0;
      frame_d = '0;
      done_d  = 1'b0;

      unique case (state_q)
        IDLE:   emit = enable;
        ACTIVE: emit = 1'b1;
        GAP: begin
          if (gap_last) begin
            gap_d   = '0;
            state_d = enable ? ACTIVE : IDLE;
          end else begin
            gap_d = GAP_W'(gap_q + 1'b1);
          end
        end
        default: state_d = IDLE;
      endcase

      if (emit) begin
        vld_d         = 1'b1;
        frame_d.hc    = hc_q;
        frame_d.vc    = vc_q;
        frame_d.start = (hc_q == '0) && (vc_q == '0);
        done_d        = px_last;

        if (hc_last) begin
          hc_d = '0;
          vc_d = (vc_q == VC_LAST) ? '0 : VC_W'(vc_q + 1'b1);
        end else begin
          hc_d = HC_W'(hc_q + 1'b1);
        end

        // Frame boundary is the only point where enable can stop generation.
        if (px_last) begin
          if (FRAME_GAP > 0) begin
            state_d = GAP;
          end else begin
            state_d = enable ? ACTIVE : IDLE;
          end
        end else begin
          state_d = ACTIVE;
        end
      end

      busy_d = (state_q != IDLE) || emit;
    end
  end

`ifdef VIDEO_FRAME_SRC_FRAME_CNT_EN
  // Completed-frame counter, advanced alongside each frame_done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (!stall && done_d) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/video_frame_src.md
VIDEO_FRAME_SRC -- requirements
Module: video_frame_src

Interface
REQ-001 Parameter FRAME_GAP, default 0, sets the number of idle (sink_vld=0) non-stalled cycles inserted between consecutive frames; legal range 0..255.
REQ-002 clk  input  1  clock; all logic SHALL be rising-edge triggered.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 enable  input  1  request to generate frames; level-sensitive.
REQ-005 stall  input  1  downstream backpressure; when high, all internal and output state SHALL hold.
REQ-006 sink_vld  output  1  registered; sink_frame carries a valid pixel.
REQ-007 sink_frame  output  vga_frame_t  registered; fields hc, vc, start, r, g, b as defined in vga.svh.
REQ-008 frame_done  output  1  registered; high in the same cycle as the last pixel of a frame (hc=`H_DISPLAY-1, vc=`V_DISPLAY-1).
REQ-009 busy  output  1  registered; high while the state is ACTIVE or GAP.

Function
REQ-010 The block SHALL implement the states IDLE, ACTIVE and GAP, with state and counters advancing only on cycles where stall=0.
REQ-011 IDLE: sink_vld=0; if enable=1, the block SHALL go to ACTIVE with hc_cnt=0 and vc_cnt=0.
REQ-012 ACTIVE: each non-stalled cycle SHALL register sink_vld=1 and sink_frame.hc/vc equal to the current hc_cnt/vc_cnt; hc_cnt SHALL then increment.
REQ-013 hc_cnt SHALL wrap from `H_DISPLAY-1 to 0 while incrementing vc_cnt; vc_cnt SHALL wrap from `V_DISPLAY-1 to 0 at end of frame.
REQ-014 sink_frame.start SHALL be 1 only for the pixel hc=0, vc=0, and 0 for all other pixels.
REQ-015 sink_frame.r/g/b SHALL be 0 for every pixel; colour is filled by downstream cores.
REQ-016 After the last pixel, the next state SHALL be GAP if FRAME_GAP>0; otherwise ACTIVE if enable=1, else IDLE.
REQ-017 GAP: sink_vld=0; a gap counter SHALL count FRAME_GAP non-stalled cycles, then go to ACTIVE if enable=1, else IDLE.
REQ-018 Latency: the first pixel SHALL appear on sink_vld one clock after the cycle in which enable=1 is sampled in IDLE with stall=0.
REQ-019 Deasserting enable mid-frame SHALL NOT truncate the frame; the current frame completes and the block stops at the frame boundary.
REQ-020 While stall=1, sink_vld, sink_frame, frame_done and busy SHALL hold their previous values; no pixel SHALL be skipped or duplicated across a stall.
REQ-021 frame_done SHALL be a single non-stalled-cycle pulse per frame, coincident with that frame's last pixel.

Reset
REQ-022 On rst=1 the state SHALL be IDLE, hc_cnt=vc_cnt=0, gap counter=0, sink_vld=0, frame_done=0, busy=0, and sink_frame all fields 0.
REQ-023 rst SHALL take priority over stall and enable; rst asserted mid-frame SHALL abort the frame, and the next frame after release SHALL start at hc=0, vc=0 with start=1.

Configuration
REQ-024 Macro VIDEO_FRAME_SRC_FRAME_CNT_EN: when defined, the block SHALL add output frame_cnt [15:0], reset to 0 and incremented (wrapping 65535->0) on each frame_done pulse; when undefined, the port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification (`H_DISPLAY=640, `V_DISPLAY=480)
REQ-025 rst, then enable=1 held, stall=0, FRAME_GAP=0 -> first sink_vld one cycle later with hc=0, vc=0, start=1; 307200 consecutive valid pixels; frame_done at (639,479); next cycle (0,0) with start=1.
REQ-026 FRAME_GAP=4, enable held -> exactly 4 sink_vld=0 cycles between pixel (639,479) and the next (0,0).
REQ-027 Random stall pattern at 30% density -> the downstream pixel sequence (sampled when stall=0 and sink_vld=1) is identical to the unstalled sequence; outputs hold during stall.
REQ-028 enable dropped at pixel (100,10) -> the frame runs to (639,479), then sink_vld=0 and busy=0 until enable returns.
REQ-029 rst pulsed at pixel (300,200) -> sink_vld=0 the next cycle; after release with enable=1, output restarts at (0,0) with start=1.
REQ-030 With VIDEO_FRAME_SRC_FRAME_CNT_EN defined, 3 frames -> frame_cnt=3; force the counter to 65535 and complete one frame -> frame_cnt=0.
